serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial, LSB-first adder: accepts two WIDTH-bit operands plus a carry-in, and produces a WIDTH-bit sum plus carry-out after WIDTH add cycles.
- Drives the team's 3-input full-adder cell once per clock (a = operand A bit, b = operand B bit, c = registered carry) and registers that cell's sum/carry outputs.
- Sits directly upstream of the full-adder cell, sequencing operand bits into it and collecting its results.
- Used where area matters more than throughput.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- op_a  input  WIDTH  operand A; captured on the edge that accepts start.
- op_b  input  WIDTH  operand B; captured on the edge that accepts start.
- cin  input  1  carry-in; captured on the edge that accepts start.
- busy  output  1  high while in ADD.
- done  output  1  one-cycle pulse, high while in DONE.
- sum  output  WIDTH  result; valid from DONE until the next accepted start.
- cout  output  1  final carry; valid with sum.

Behaviour:
- Reset (asynchronous, active-high, effective immediately, any state):
  - state = IDLE; busy = 0, done = 0, sum = 0, cout = 0.
  - Internal shift registers, carry register and bit counter are cleared.
  - An operation in flight is aborted with no done pulse.
- States: IDLE, ADD, DONE; encoding is free.
- IDLE:
  - On an edge with start = 1: load shA = op_a, shB = op_b, carry = cin, cnt = 0, clear the sum shift register, go to ADD.
  - With start = 0: stay in IDLE; sum and cout hold.
- ADD, one bit per edge:
  - Full-adder inputs are a = shA[0], b = shB[0], c = carry.
  - Its sum bit shifts into the sum register at the MSB (shift right); carry is updated from the cell's carry output.
  - shA and shB shift right by 1; cnt increments.
  - On the edge where cnt = WIDTH-1 (the last bit): go to DONE. After that edge the sum register holds the full result and cout = carry.
- DONE: held for exactly one cycle, then returns to IDLE unconditionally.
- Latency:
  - The edge sampling start is edge 0; done is high in the cycle following edge WIDTH.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start is ignored in ADD and in DONE; it is never queued.
- Operand inputs are don't-care except on the accepting edge. Changing them mid-operation has no effect.
- Arithmetic: {cout, sum} = op_a + op_b + cin, modulo 2^(WIDTH+1).
- WIDTH = 1 is legal: ADD lasts a single edge.
- sum and cout are held stable from DONE until the next accepted start. On that start edge the sum register is cleared; sum is not valid during busy.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), captured with the operands.
  - If sub = 1: shB loads ~op_b and the carry register loads 1; cin is ignored. The result is op_a - op_b modulo 2^WIDTH.
  - In subtract mode, cout = 1 means no borrow and cout = 0 means borrow.
  - If sub = 0: behaviour is identical to the base block.
- When undefined: no sub port and no extra logic; the block is addition only.

Test Plan:
- Reset: assert rst asynchronously between edges -> outputs 0 immediately, state IDLE; release, hold start = 0 for 5 cycles -> busy = 0, done = 0 throughout.
- Basic add, WIDTH = 8: op_a = 8'h5A, op_b = 8'h3C, cin = 0, start for 1 cycle -> busy high for 8 cycles, done pulses once in the cycle after edge 8, sum = 8'h96, cout = 0. sum and cout hold until the next start.
- Carry ripple / wrap: 8'hFF + 8'h01, cin = 0 -> sum = 8'h00, cout = 1. Then 8'hFF + 8'hFF, cin = 1 -> sum = 8'hFF, cout = 1.
- Ignored start and operand change: during ADD, pulse start and change op_a/op_b to 8'h00 -> result unchanged (first operation's sum), exactly one done pulse. A start during DONE is also ignored. Back-to-back starts achieve spacing of exactly 10 cycles.
- Reset mid-operation: assert rst at cycle 4 of ADD -> no done pulse, sum = 0. Then a fresh 8'h01 + 8'h01 -> sum = 8'h02, cout = 0.
- SUB_EN (macro defined): 8'h10 - 8'h01, sub = 1 -> sum = 8'h0F, cout = 1. Then 8'h01 - 8'h02 -> sum = 8'hFF, cout = 0. Then sub = 0 with 8'h5A + 8'h3C -> 8'h96.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The optional subtract control (sub) exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Requester side: issues operands, observes status and result.
  modport master (
    output start, op_a, op_b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout
  );

  // Adder side: consumes operands, drives status and result.
  modport slave (
    input  start, op_a, op_b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder evaluation per clock, WIDTH
// add cycles per operation, result valid from DONE until the next start.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sha_reg, sha_next;
  logic [WIDTH-1:0] shb_reg, shb_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Full-adder cell operands: current LSBs and the registered carry.
  logic fa_a, fa_b, fa_sum, fa_carry;
  assign fa_a     = sha_reg[0];
  assign fa_b     = shb_reg[0];
  assign fa_sum   = fa_a ^ fa_b ^ carry_reg;
  assign fa_carry = (fa_a & fa_b) | (fa_a & carry_reg) | (fa_b & carry_reg);

  // Sum register shifted right by one with the new bit entering at the MSB.
  logic [WIDTH-1:0] sum_shift;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_sum_shift
      assign sum_shift[gi] = sum_reg[gi+1];
    end
  endgenerate
  assign sum_shift[WIDTH-1] = fa_sum;

  // Operand B and carry seed as loaded on an accepted start.
  logic [WIDTH-1:0] load_b;
  logic             load_carry;
`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so the caller's carry-in is ignored.
  assign load_b     = bus.sub ? ~bus.op_b : bus.op_b;
  assign load_carry = bus.sub ? 1'b1 : bus.cin;
`else
  assign load_b     = bus.op_b;
  assign load_carry = bus.cin;
`endif

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sha_reg   <= '0;
      shb_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sha_reg   <= sha_next;
      shb_reg   <= shb_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    state_next = state_reg;
    sha_next   = sha_reg;
    shb_next   = shb_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          sha_next   = bus.op_a;
          shb_next   = load_b;
          carry_next = load_carry;
          cnt_next   = '0;
          sum_next   = '0;
          state_next = ADD;
        end
      end
      ADD: begin
        sha_next   = sha_reg >> 1;
        shb_next   = shb_reg >> 1;
        sum_next   = sum_shift;
        carry_next = fa_carry;
        cnt_next   = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_BIT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The carry register already holds the final carry once ADD completes
  // and is not touched again until the next accepted start.
  assign bus.busy = (state_reg == ADD);
  assign bus.done = (state_reg == DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = carry_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH = 8). Subtract vectors run
// only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int accept_cyc = 0;
  int prev_accept_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // One operation: start accepted at edge 0, then observe edges 1..9.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic sb, input logic [W-1:0] exp_sum,
                       input logic exp_cout, input bit disturb, input bit hold,
                       input bit chk_spacing);
    int busy_cnt;
    int done_cnt;
    int done_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = sb;
`else
    if (sb) $display("note %s: sub requested without subtract build", tag);
`endif
    bus.start = 1'b1;
    tick;
    prev_accept_cyc = accept_cyc;
    accept_cyc      = cycle;
    bus.start = 1'b0;
    bus.op_a  = W'($urandom);
    bus.op_b  = W'($urandom);
    bus.cin   = 1'($urandom);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_at = k;
      end
      if (disturb && k == 3) begin
        bus.start = 1'b1;
        bus.op_a  = '0;
        bus.op_b  = '0;
      end
      if (disturb && k == 4) bus.start = 1'b0;
      if (disturb && k == 8) bus.start = 1'b1;
      if (disturb && k == 9) bus.start = 1'b0;
    end
    check({tag, " busy_cycles"}, busy_cnt, 8);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " done_edge"}, done_at, 8);
    check({tag, " sum"}, bus.sum, exp_sum);
    check({tag, " cout"}, bus.cout, exp_cout);
    if (chk_spacing) check({tag, " spacing"}, accept_cyc - prev_accept_cyc, 10);
    if (hold) begin
      tick;
      tick;
      check({tag, " sum_hold"}, bus.sum, exp_sum);
      check({tag, " cout_hold"}, bus.cout, exp_cout);
    end
  endtask

  initial begin
    int done_seen;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif

    // Power-on reset asserted between edges.
    #2 rst = 1'b1;
    #1;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset sum", bus.sum, 0);
    check("reset cout", bus.cout, 0);
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      check($sformatf("idle%0d busy", i), bus.busy, 0);
      check($sformatf("idle%0d done", i), bus.done, 0);
    end

    do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 0, 1, 0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1, 0);
    do_op("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 0, 0, 0);
    // Disturbed op followed immediately by a back-to-back op.
    do_op("disturb_12_34", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1, 0, 0);
    do_op("b2b_80_80_c1", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 0, 0, 1);

    // Reset in the middle of ADD: aborts with no done pulse.
    bus.op_a  = 8'h5A;
    bus.op_b  = 8'h3C;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    check("midop busy_before", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midop rst busy", bus.busy, 0);
    check("midop rst sum", bus.sum, 0);
    check("midop rst cout", bus.cout, 0);
    tick;
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (bus.done) done_seen++;
    end
    check("midop no_done", done_seen, 0);
    check("midop sum_after", bus.sum, 0);
    do_op("add_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 0, 0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 0, 0, 0);
    do_op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 0, 0, 0);
    do_op("nosub_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
